eflash_output_buffer: RTL and testbench
=======================================

# eflash_output_buffer

Return-path buffer of the eFlash macro. It captures the per-column ADC results produced while the row driver pulses ADC_EN, and in PIM mode shift-accumulates them across 2-bit input slices. It then hands the results back to the Peri controller as sixteen 32-bit words under a counted read strobe. It is the read-side counterpart of the input buffer, which unpacks 32-bit words into per-column drive data.

## Interface
Parameters:
- NUM_COL, 32: number of ADC lanes.
- ADC_W, 8: ADC result width, unsigned.
- ACC_W, 16: accumulator width per lane.
- NUM_SLICES, 4: exec passes per PIM operation.

Ports:
- clk_i  in  1  single clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- pim_en_i  in  1  operation enable from Peri controller.
- pim_mode_i  in  3  mode, values from eflash_pkg.
- exec_cnt_i  in  4  current slice index.
- adc_valid_i  in  1  one-cycle strobe; adc_data_i is valid.
- adc_data_i  in  ADC_W x [0:NUM_COL-1]  per-lane ADC result.
- out_buf_read_i  in  1  one-cycle strobe; consume current word.
- out_buf_clear_i  in  1  synchronous flush.
- output_data_o  out  32  current word.
- output_valid_o  out  1  buffer holds unread result.
- data_tx_cnt_o  out  4  index of current word.
- overrun_o  out  1  sticky: ADC strobe dropped.
- seq_err_o  out  1  sticky: slice out of order.

## Operation
- States:
  - IDLE: empty.
  - ACCUM: PIM slices in progress.
  - READY: result held and being read out.
- Mode constants:
  - MODE_READ = 3'd1: single capture, no accumulation.
  - MODE_PIM = 3'd2: shift-accumulate over slices.
  - Any other mode: the strobe is ignored.
- IDLE, strobe with pim_en_i=1:
  - MODE_READ: acc[i] ← zero-extend(adc[i]), go to READY.
  - MODE_PIM with exec_cnt_i=0: acc[i] ← adc[i], expected ← 1, go to ACCUM.
  - MODE_PIM with NUM_SLICES=1: go directly to READY.
  - MODE_PIM with exec_cnt_i≠0: strobe dropped, seq_err_o set.
- ACCUM, strobe:
  - exec_cnt_i == expected: acc[i] ← acc[i] + (adc[i] << 2·exec_cnt_i), expected++.
  - After the slice NUM_SLICES-1: go to READY.
  - exec_cnt_i == 0: restart the accumulation (acc[i] ← adc[i], expected ← 1).
  - Any other value: set seq_err_o, stay, acc unchanged.
- ACCUM, pim_en_i falls: abort to IDLE, acc zeroed.
- Arithmetic:
  - Unsigned, truncated to ACC_W.
  - Defaults give a maximum of 255·85 = 21675, so no overflow.
- Packing: word w = {acc[2w+1], acc[2w]}, w = 0..15.
- READY:
  - output_valid_o=1 and output_data_o = word[data_tx_cnt_o].
  - Each out_buf_read_i increments data_tx_cnt_o.
  - A read at index 15 returns to IDLE with data_tx_cnt_o=0.
- out_buf_read_i outside READY: ignored.
- Strobe while in READY: dropped, overrun_o set, buffer untouched.
- out_buf_clear_i:
  - From any state: go to IDLE; acc, counters, overrun_o and seq_err_o all cleared.
  - Highest priority over all simultaneous events.
- Last read and strobe in the same cycle: the strobe counts as in READY, so it is dropped and overrun_o is set.

## Timing
- Reset values:
  - State is IDLE, all acc are 0.
  - output_data_o=0, output_valid_o=0, data_tx_cnt_o=0, overrun_o=0, seq_err_o=0.
- Completing strobe at edge n: output_valid_o=1 from cycle n+1, with word 0 on output_data_o.
- output_data_o is a combinational mux of registered acc and the registered counter, so it is valid in the same cycle as output_valid_o.
- After a read at edge n, the next word appears in cycle n+1.
- Throughput: one word per cycle with back-to-back reads; 16 cycles to drain.
- Reset asserted mid-operation: immediate asynchronous return to the reset values; any partial accumulation is lost.

## Structure
- eflash_pkg holds:
  - MODE_READ and MODE_PIM.
  - Enum state_t {IDLE, ACCUM, READY}.
  - The NUM_COL, ADC_W, ACC_W and NUM_SLICES defaults.
  - Localparam NUM_WORDS = NUM_COL·ACC_W/32.
- Sub-module out_acc_lane, instantiated NUM_COL times:
  - One ACC_W register.
  - Load / shift-add / clear controls, driven by the top-level FSM.

## Test plan
- MODE_READ capture: adc[i]=i+1, one strobe, then 16 reads.
  - Required: word0 = 0x0002_0001, word15 = 0x0020_001F.
  - Required: output_valid_o falls after the 16th read.
- MODE_PIM, 4 slices with exec 0..3, all adc=255.
  - Required: every lane reads 0x54AB, every word = 0x54AB_54AB.
  - Required: valid rises the cycle after the exec=3 strobe.
- PIM order error: slices 0, then 2.
  - Required: seq_err_o=1, state stays ACCUM.
  - Then slices 1, 2, 3: correct result, seq_err_o stays 1.
- Overrun: a strobe while READY with data_tx_cnt_o=5.
  - Required: overrun_o=1, data_tx_cnt_o stays 5, words unchanged.
- Last read at index 15 in the same cycle as a strobe.
  - Required: go to IDLE and overrun_o=1.
- Clear and abort:
  - Clear mid-readout → all zero and IDLE; a following read is ignored.
  - pim_en_i dropped after slice 1 → IDLE and output_valid_o=0.
  - rst_ni pulsed mid-ACCUM → reset values.

Source files
------------

// File: rtl/eflash_pkg.sv
// Shared constants and types for the eFlash return-path buffer.
package eflash_pkg;

  localparam logic [2:0] MODE_READ = 3'd1;
  localparam logic [2:0] MODE_PIM  = 3'd2;

  typedef enum logic [1:0] {IDLE, ACCUM, READY} state_t;

  localparam int unsigned NUM_COL_DEF    = 32;
  localparam int unsigned ADC_W_DEF      = 8;
  localparam int unsigned ACC_W_DEF      = 16;
  localparam int unsigned NUM_SLICES_DEF = 4;
  localparam int unsigned NUM_WORDS      = NUM_COL_DEF * ACC_W_DEF / 32;

endpackage

// File: rtl/out_acc_lane.sv
// One ADC lane accumulator: load, shift-add or clear, controlled by the buffer FSM.
module out_acc_lane #(
  parameter int unsigned ADC_W = 8,
  parameter int unsigned ACC_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             add_i,
  input  logic [4:0]       shamt_i,
  input  logic [ADC_W-1:0] adc_i,
  output logic [ACC_W-1:0] acc_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] addend;

  assign addend = ACC_W'(adc_i) << shamt_i;

  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (load_i) begin
      acc_d = ACC_W'(adc_i);
    end else if (add_i) begin
      acc_d = acc_q + addend;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/eflash_output_buffer.sv
// Captures per-column ADC results, shift-accumulates PIM slices and streams them out
// as 32-bit words under a counted read strobe.
module eflash_output_buffer
  import eflash_pkg::*;
#(
  parameter int unsigned NUM_COL    = NUM_COL_DEF,
  parameter int unsigned ADC_W      = ADC_W_DEF,
  parameter int unsigned ACC_W      = ACC_W_DEF,
  parameter int unsigned NUM_SLICES = NUM_SLICES_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             pim_en_i,
  input  logic [2:0]       pim_mode_i,
  input  logic [3:0]       exec_cnt_i,
  input  logic             adc_valid_i,
  input  logic [ADC_W-1:0] adc_data_i [0:NUM_COL-1],
  input  logic             out_buf_read_i,
  input  logic             out_buf_clear_i,
  output logic [31:0]      output_data_o,
  output logic             output_valid_o,
  output logic [3:0]       data_tx_cnt_o,
  output logic             overrun_o,
  output logic             seq_err_o
);

  localparam int unsigned N_WORDS    = NUM_COL * ACC_W / 32;
  localparam logic [3:0]  LAST_WORD  = 4'(N_WORDS - 1);
  localparam logic [3:0]  LAST_SLICE = 4'(NUM_SLICES - 1);

  state_t     state_q, state_d;
  logic [3:0] expected_q, expected_d;
  logic [3:0] tx_cnt_q, tx_cnt_d;
  logic       overrun_q, overrun_d;
  logic       seq_err_q, seq_err_d;
  logic       lane_clear, lane_load, lane_add;

  logic [NUM_COL*ACC_W-1:0] acc_flat;
  logic [31:0]              words [N_WORDS];

  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    tx_cnt_d   = tx_cnt_q;
    overrun_d  = overrun_q;
    seq_err_d  = seq_err_q;
    lane_clear = 1'b0;
    lane_load  = 1'b0;
    lane_add   = 1'b0;
    if (out_buf_clear_i) begin
      state_d    = IDLE;
      expected_d = '0;
      tx_cnt_d   = '0;
      overrun_d  = 1'b0;
      seq_err_d  = 1'b0;
      lane_clear = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (adc_valid_i && pim_en_i) begin
            if (pim_mode_i == MODE_READ) begin
              lane_load = 1'b1;
              state_d   = READY;
            end else if (pim_mode_i == MODE_PIM) begin
              if (exec_cnt_i == 4'd0) begin
                lane_load  = 1'b1;
                expected_d = 4'd1;
                state_d    = (NUM_SLICES == 1) ? READY : ACCUM;
              end else begin
                seq_err_d = 1'b1;
              end
            end
          end
        end
        ACCUM: begin
          if (!pim_en_i) begin
            state_d    = IDLE;
            expected_d = '0;
            lane_clear = 1'b1;
          end else if (adc_valid_i && pim_mode_i == MODE_PIM) begin
            if (exec_cnt_i == expected_q) begin
              lane_add   = 1'b1;
              expected_d = expected_q + 4'd1;
              if (exec_cnt_i == LAST_SLICE) begin
                state_d    = READY;
                expected_d = '0;
              end
            end else if (exec_cnt_i == 4'd0) begin
              // Slice 0 arriving mid-operation restarts the accumulation.
              lane_load  = 1'b1;
              expected_d = 4'd1;
            end else begin
              seq_err_d = 1'b1;
            end
          end
        end
        READY: begin
          if (adc_valid_i) begin
            overrun_d = 1'b1;
          end
          if (out_buf_read_i) begin
            if (tx_cnt_q == LAST_WORD) begin
              state_d  = IDLE;
              tx_cnt_d = '0;
            end else begin
              tx_cnt_d = tx_cnt_q + 4'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      expected_q <= '0;
      tx_cnt_q   <= '0;
      overrun_q  <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      tx_cnt_q   <= tx_cnt_d;
      overrun_q  <= overrun_d;
      seq_err_q  <= seq_err_d;
    end
  end

  for (genvar i = 0; i < NUM_COL; i++) begin : g_lane
    out_acc_lane #(
      .ADC_W (ADC_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (lane_clear),
      .load_i  (lane_load),
      .add_i   (lane_add),
      .shamt_i ({exec_cnt_i, 1'b0}),
      .adc_i   (adc_data_i[i]),
      .acc_o   (acc_flat[i*ACC_W +: ACC_W])
    );
  end

  for (genvar w = 0; w < N_WORDS; w++) begin : g_word
    assign words[w] = acc_flat[w*32 +: 32];
  end

  assign output_data_o  = words[tx_cnt_q];
  assign output_valid_o = (state_q == READY);
  assign data_tx_cnt_o  = tx_cnt_q;
  assign overrun_o      = overrun_q;
  assign seq_err_o      = seq_err_q;

endmodule

// File: tb/tb_eflash_output_buffer.sv
// Scoreboard bench: expected words are queued at capture time and popped on each read.
module tb_eflash_output_buffer;
  import eflash_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pim_en;
  logic [2:0]  pim_mode;
  logic [3:0]  exec_cnt;
  logic        adc_valid;
  logic [7:0]  adc_data [0:31];
  logic        out_buf_read;
  logic        out_buf_clear;
  logic [31:0] output_data;
  logic        output_valid;
  logic [3:0]  data_tx_cnt;
  logic        overrun;
  logic        seq_err;

  logic [15:0] exp_acc [32];
  logic [31:0] sb [$];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  eflash_output_buffer dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .pim_en_i        (pim_en),
    .pim_mode_i      (pim_mode),
    .exec_cnt_i      (exec_cnt),
    .adc_valid_i     (adc_valid),
    .adc_data_i      (adc_data),
    .out_buf_read_i  (out_buf_read),
    .out_buf_clear_i (out_buf_clear),
    .output_data_o   (output_data),
    .output_valid_o  (output_valid),
    .data_tx_cnt_o   (data_tx_cnt),
    .overrun_o       (overrun),
    .seq_err_o       (seq_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_adc();
    for (int i = 0; i < 32; i++) adc_data[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic model_load();
    for (int i = 0; i < 32; i++) exp_acc[i] = 16'(adc_data[i]);
  endtask

  task automatic model_add(input int e);
    for (int i = 0; i < 32; i++) exp_acc[i] = exp_acc[i] + (16'(adc_data[i]) << (2 * e));
  endtask

  task automatic push_words();
    for (int w = 0; w < 16; w++) sb.push_back({exp_acc[2*w+1], exp_acc[2*w]});
  endtask

  task automatic strobe(input logic [2:0] mode, input logic [3:0] e);
    pim_mode  = mode;
    exec_cnt  = e;
    adc_valid = 1'b1;
    tick();
    adc_valid = 1'b0;
  endtask

  task automatic read_word(input int k);
    logic [31:0] e;
    e = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
    check("valid", {31'd0, output_valid}, 32'd1);
    check("tx_cnt", {28'd0, data_tx_cnt}, k);
    check("word", output_data, e);
    out_buf_read = 1'b1;
    tick();
    out_buf_read = 1'b0;
  endtask

  task automatic clear_pulse();
    out_buf_clear = 1'b1;
    tick();
    out_buf_clear = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_data"}, output_data, 32'd0);
    check({tag, "_valid"}, {31'd0, output_valid}, 32'd0);
    check({tag, "_cnt"}, {28'd0, data_tx_cnt}, 32'd0);
    check({tag, "_ovr"}, {31'd0, overrun}, 32'd0);
    check({tag, "_seq"}, {31'd0, seq_err}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; pim_en = 1'b0; pim_mode = 3'd0; exec_cnt = 4'd0;
    adc_valid = 1'b0; out_buf_read = 1'b0; out_buf_clear = 1'b0;
    for (int i = 0; i < 32; i++) adc_data[i] = 8'd0;
    repeat (2) tick();
    check_reset_vals("rst");
    rst_n = 1'b1;
    tick();

    // Single capture, ramp data
    pim_en = 1'b1;
    for (int i = 0; i < 32; i++) adc_data[i] = 8'(i + 1);
    model_load(); push_words();
    strobe(MODE_READ, 4'd0);
    check("rd_word0", output_data, 32'h0002_0001);
    for (int k = 0; k < 16; k++) begin
      if (k == 15) check("rd_word15", output_data, 32'h0020_001F);
      read_word(k);
    end
    check("rd_valid_fall", {31'd0, output_valid}, 32'd0);
    check("rd_cnt_wrap", {28'd0, data_tx_cnt}, 32'd0);

    // PIM, all lanes 255
    for (int i = 0; i < 32; i++) adc_data[i] = 8'hFF;
    model_load();
    strobe(MODE_PIM, 4'd0);
    for (int e = 1; e < 4; e++) begin
      check("pim_not_valid", {31'd0, output_valid}, 32'd0);
      model_add(e);
      strobe(MODE_PIM, 4'(e));
    end
    check("pim_valid_rise", {31'd0, output_valid}, 32'd1);
    check("pim_const", output_data, 32'h54AB_54AB);
    push_words();
    for (int k = 0; k < 16; k++) read_word(k);

    // Slice order error, then recovery
    rand_adc(); model_load();
    strobe(MODE_PIM, 4'd0);
    rand_adc();
    strobe(MODE_PIM, 4'd2);
    check("seq_set", {31'd0, seq_err}, 32'd1);
    check("seq_no_valid", {31'd0, output_valid}, 32'd0);
    for (int e = 1; e < 4; e++) begin
      rand_adc(); model_add(e);
      strobe(MODE_PIM, 4'(e));
    end
    check("seq_sticky", {31'd0, seq_err}, 32'd1);
    push_words();
    for (int k = 0; k < 16; k++) read_word(k);

    clear_pulse();
    check("clr_seq", {31'd0, seq_err}, 32'd0);

    // Overrun while reading at index 5
    rand_adc(); model_load(); push_words();
    strobe(MODE_READ, 4'd0);
    for (int k = 0; k < 5; k++) read_word(k);
    rand_adc();
    strobe(MODE_READ, 4'd0);
    check("ovr_set", {31'd0, overrun}, 32'd1);
    check("ovr_cnt", {28'd0, data_tx_cnt}, 32'd5);
    for (int k = 5; k < 16; k++) read_word(k);
    check("ovr_drained", {31'd0, output_valid}, 32'd0);

    clear_pulse();
    check("clr_ovr", {31'd0, overrun}, 32'd0);

    // Last read coincident with a strobe
    rand_adc(); model_load(); push_words();
    strobe(MODE_READ, 4'd0);
    for (int k = 0; k < 15; k++) read_word(k);
    check("last_word", output_data, sb.size() > 0 ? sb.pop_front() : 32'hDEAD_BEEF);
    rand_adc();
    out_buf_read = 1'b1; adc_valid = 1'b1; pim_mode = MODE_READ;
    tick();
    out_buf_read = 1'b0; adc_valid = 1'b0;
    check("last_idle", {31'd0, output_valid}, 32'd0);
    check("last_cnt", {28'd0, data_tx_cnt}, 32'd0);
    check("last_ovr", {31'd0, overrun}, 32'd1);

    // Clear mid-readout, then a stray read
    clear_pulse();
    rand_adc(); model_load(); push_words();
    strobe(MODE_READ, 4'd0);
    for (int k = 0; k < 3; k++) read_word(k);
    clear_pulse();
    sb.delete();
    check_reset_vals("clr");
    out_buf_read = 1'b1;
    tick();
    out_buf_read = 1'b0;
    check("clr_read_cnt", {28'd0, data_tx_cnt}, 32'd0);
    check("clr_read_valid", {31'd0, output_valid}, 32'd0);

    // Abort by dropping pim_en after slice 1
    rand_adc();
    strobe(MODE_PIM, 4'd0);
    strobe(MODE_PIM, 4'd1);
    pim_en = 1'b0;
    tick();
    pim_en = 1'b1;
    check("abort_valid", {31'd0, output_valid}, 32'd0);
    check("abort_data", output_data, 32'd0);
    strobe(MODE_PIM, 4'd2);  // back in IDLE, so a non-zero slice is out of order
    check("abort_idle_seq", {31'd0, seq_err}, 32'd1);
    check("abort_idle_valid", {31'd0, output_valid}, 32'd0);
    clear_pulse();

    // Asynchronous reset mid-accumulation
    rand_adc();
    adc_data[0] = 8'h5A;
    strobe(MODE_PIM, 4'd0);
    strobe(MODE_PIM, 4'd3);
    check("pre_rst_seq", {31'd0, seq_err}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("arst");
    #2 rst_n = 1'b1;
    tick();
    strobe(MODE_PIM, 4'd1);
    check("arst_idle_seq", {31'd0, seq_err}, 32'd1);
    check("arst_idle_valid", {31'd0, output_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
